// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Computes {bout, diff} = a - b - bin with a start/busy/done handshake.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] ra_q;
  logic [WIDTH-1:0] rb_q;
  logic [WIDTH-2:0] acc_q;
  logic             bw_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;

  logic             x;
  logic             y;
  logic             d_bit;
  logic             bw_d;
  logic [WIDTH-1:0] acc_d;

  always_comb begin
    x     = ra_q[0];
    y     = rb_q[0];
    d_bit = x ^ y ^ bw_q;
    bw_d  = (~x & y) | (~(x ^ y) & bw_q);
    acc_d = {d_bit, acc_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      acc_q   <= '0;
      bw_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            ra_q    <= a;
            rb_q    <= b;
            bw_q    <= bin;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          ra_q  <= ra_q >> 1;
          rb_q  <= rb_q >> 1;
          bw_q  <= bw_d;
          acc_q <= acc_d[WIDTH-1:1];
          cnt_q <= cnt_q + CW'(1);
          // result registers move only on the final bit
          if (cnt_q == LAST) begin
            diff_q  <= acc_d;
            bout_q  <= bw_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub: timeline/arithmetic reference model with
// per-cycle compare, plus directed literal vectors.
module tb_serial_sub;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         bin   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int checks = 0;
  int errors = 0;

  serial_sub #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: ph counts cycles since acceptance; result is plain arithmetic.
  int           ph     = 0;
  logic [W:0]   m_res  = '0;
  logic [W-1:0] m_diff = '0;
  logic         m_bout = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph     = 0;
      m_diff = '0;
      m_bout = 1'b0;
    end else if (ph == 0) begin
      if (start) begin
        m_res = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        ph    = 1;
      end
    end else begin
      ph++;
      if (ph == W + 1) begin
        m_diff = m_res[W-1:0];
        m_bout = m_res[W];
      end else if (ph == W + 2) begin
        ph = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, (ph != 0));
    chk("done", done, (ph == W + 1));
    chk("diff", diff, m_diff);
    chk("bout", bout, m_bout);
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tbin, input logic [W-1:0] ed,
                        input logic eb, input logic [W-1:0] prev,
                        input bit inj, input string nm);
    int n;
    int bc;
    bit seen;
    @(negedge clk);
    a     = ta;
    b     = tb_;
    bin   = tbin;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    bin   = 1'($urandom);
    n     = 0;
    bc    = 0;
    seen  = 1'b0;
    while (busy && n < 3 * W) begin
      if (done) begin
        seen = 1'b1;
        chk({nm, "_lat"}, n, W);
        chk({nm, "_diff"}, diff, ed);
        chk({nm, "_bout"}, bout, eb);
        chk({nm, "_model"}, {m_bout, m_diff}, {eb, ed});
      end else if (!seen) begin
        chk({nm, "_hold"}, diff, prev);
      end
      if (inj && n == 3) begin
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h00;
      end
      if (inj && n == 4) start = 1'b0;
      bc++;
      @(negedge clk);
      n++;
    end
    chk({nm, "_seen"}, seen, 1);
    chk({nm, "_busy"}, bc, W + 1);
  endtask

  initial begin
    int ndone;
    int last;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    rst_n = 1'b1;

    run_op(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 8'h00, 1'b0, "t1");
    run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 8'h23, 1'b0, "t2a");
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'hFF, 1'b0, "t2b");
    run_op(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 8'hFF, 1'b0, "t3");
    run_op(8'h5A, 8'h0F, 1'b0, 8'h4B, 1'b0, 8'h00, 1'b1, "t4");

    @(negedge clk);
    a     = 8'h77;
    b     = 8'h11;
    bin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_diff", diff, 0);
    chk("t5_bout", bout, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 8'h00, 1'b0, "t5b");

    @(negedge clk);
    start = 1'b1;
    ndone = 0;
    last  = 0;
    for (int c = 0; c < 200 * (W + 2) + 50 && ndone < 200; c++) begin
      @(negedge clk);
      a   = W'($urandom);
      b   = W'($urandom);
      bin = 1'($urandom);
      if (done) begin
        if (ndone > 0) chk("t6_gap", c - last, W + 2);
        last = c;
        ndone++;
        if (ndone == 200) start = 1'b0;
      end
    end
    start = 1'b0;
    chk("t6_runs", ndone, 200);
    repeat (3) @(negedge clk);
    chk("t6_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
